spi_tx: RTL and testbench

Slave-side SPI transmitter that returns register read data on `miso`. It sits directly downstream of the SPI receiver. When the receiver raises `tx_req` at the end of the dummy phase of a read command, this block latches the 16-bit read word. It then shifts the word out MSB-first over the following 16 `sclk` cycles (SPI mode 0), and reports completion or abort to the system side.

---
 rtl/spi_tx_if.sv | 25 ++
 rtl/spi_tx.sv | 168 ++++++++++++++++
 tb/tb_spi_tx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_tx_if.sv
// Bus bundle between the SPI receiver / pad ring and the spi_tx transmitter.
// The slave modport is the transmitter's view; master is the driving side.
interface spi_tx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  tx_req;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  sclk;
    logic                  ssn;
    logic                  miso;
    logic                  miso_oe;
    logic                  tx_busy;
    logic                  tx_done;
    logic                  tx_abort;

    modport slave (
        input  tx_req, tx_data, sclk, ssn,
        output miso, miso_oe, tx_busy, tx_done, tx_abort
    );

    modport master (
        output tx_req, tx_data, sclk, ssn,
        input  miso, miso_oe, tx_busy, tx_done, tx_abort
    );
endinterface

// File: rtl/spi_tx.sv
// Slave-side SPI mode-0 transmitter: latches a read word on tx_req and
// shifts it out MSB-first on miso, one bit per sclk falling edge.
module spi_tx #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic    clk,
    input  logic    reset,
    spi_tx_if.slave bus
);
    localparam int CNT_W = 5;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE, ABORT} state_t;

    // Synchronizers, history flops and registered edge strobes
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ssn_sync_q, ssn_sync_d;
    logic                   sclk_hist_q, sclk_hist_d;
    logic                   ssn_hist_q, ssn_hist_d;
    logic                   sclk_rise_q, sclk_rise_d;
    logic                   sclk_fall_q, sclk_fall_d;
    logic                   ssn_rise_q, ssn_rise_d;
    logic                   ssn_synced;

    // Frame state and registered outputs
    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   sampled_q, sampled_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic                   tx_busy_q, tx_busy_d;
    logic                   tx_done_q, tx_done_d;
    logic                   tx_abort_q, tx_abort_d;

    assign ssn_synced = ssn_sync_q[SYNC_STAGES-1];

    // Resynchronize the raw pins and derive single-cycle edge strobes
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
        ssn_sync_d  = {ssn_sync_q[SYNC_STAGES-2:0], bus.ssn};
        sclk_hist_d = sclk_sync_q[SYNC_STAGES-1];
        ssn_hist_d  = ssn_synced;
        sclk_rise_d = sclk_sync_q[SYNC_STAGES-1] & ~sclk_hist_q;
        sclk_fall_d = ~sclk_sync_q[SYNC_STAGES-1] & sclk_hist_q;
        ssn_rise_d  = ssn_synced & ~ssn_hist_q;
    end

    // Next-state and next-output logic of the transmit FSM
    always_comb begin
        // NOTE: every _d gets its hold value first, so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        sampled_d  = sampled_q;
        miso_d     = miso_q;
        miso_oe_d  = miso_oe_q;
        tx_busy_d  = tx_busy_q;
        tx_done_d  = 1'b0;
        tx_abort_d = 1'b0;

        case (state_q)
            IDLE: begin
                miso_d    = 1'b0;
                miso_oe_d = 1'b0;
                tx_busy_d = 1'b0;
                if (bus.tx_req && !ssn_synced) begin
                    // tx_data is only valid alongside tx_req, so it is captured here
                    shift_d   = bus.tx_data;
                    miso_oe_d = 1'b1;
                    tx_busy_d = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                bit_cnt_d = '0;
                sampled_d = 1'b0;
                if (ssn_rise_q) begin
                    // master deselected before the first bit: treat like a mid-frame abort
                    shift_d    = '0;
                    miso_d     = 1'b0;
                    miso_oe_d  = 1'b0;
                    tx_abort_d = 1'b1;
                    state_d    = ABORT;
                end else begin
                    miso_d  = shift_q[DATA_WIDTH-1];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ssn_rise_q) begin
                    shift_d    = '0;
                    miso_d     = 1'b0;
                    miso_oe_d  = 1'b0;
                    tx_abort_d = 1'b1;
                    state_d    = ABORT;
                end else if (sclk_rise_q) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    sampled_d = 1'b1;
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        shift_d   = '0;
                        miso_d    = 1'b0;
                        miso_oe_d = 1'b0;
                        tx_done_d = 1'b1;
                        state_d   = DONE;
                    end
                end else if (sclk_fall_q && sampled_q) begin
                    // a fall not preceded by a sampled rise would skip the MSB
                    shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
                    sampled_d = 1'b0;
                    miso_d    = shift_q[DATA_WIDTH-2];
                end
            end
            DONE, ABORT: begin
                tx_busy_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers for synchronizers and FSM
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the datapath (shift_q, miso_q) is reset as well, so miso is never X after reset.
        if (!reset) begin
            sclk_sync_q <= '0;
            ssn_sync_q  <= '1;
            sclk_hist_q <= 1'b0;
            ssn_hist_q  <= 1'b1;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            ssn_rise_q  <= 1'b0;
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            sampled_q   <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            tx_busy_q   <= 1'b0;
            tx_done_q   <= 1'b0;
            tx_abort_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            sclk_sync_q <= sclk_sync_d;
            ssn_sync_q  <= ssn_sync_d;
            sclk_hist_q <= sclk_hist_d;
            ssn_hist_q  <= ssn_hist_d;
            sclk_rise_q <= sclk_rise_d;
            sclk_fall_q <= sclk_fall_d;
            ssn_rise_q  <= ssn_rise_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            sampled_q   <= sampled_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            tx_busy_q   <= tx_busy_d;
            tx_done_q   <= tx_done_d;
            tx_abort_q  <= tx_abort_d;
        end
    end

    assign bus.miso     = miso_q;
    assign bus.miso_oe  = miso_oe_q;
    assign bus.tx_busy  = tx_busy_q;
    assign bus.tx_done  = tx_done_q;
    assign bus.tx_abort = tx_abort_q;
endmodule

// File: tb/tb_spi_tx.sv
// Self-checking bench for spi_tx: a mode-0 SPI master model samples miso on
// each rising sclk and compares against a scoreboard queue of expected bits.
module tb_spi_tx;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    spi_tx_if #(.DATA_WIDTH(W)) bus ();

    spi_tx #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    logic exp_q[$];

    int done_cnt  = 0;
    int abort_cnt = 0;
    int busy_cnt  = 0;
    int oe_cnt    = 0;
    int x_cnt     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (bus.tx_done === 1'b1)  done_cnt++;
        if (bus.tx_abort === 1'b1) abort_cnt++;
        if (bus.tx_busy === 1'b1)  busy_cnt++;
        if (bus.miso_oe === 1'b1)  oe_cnt++;
        if ($isunknown({bus.miso, bus.miso_oe, bus.tx_busy, bus.tx_done, bus.tx_abort})) x_cnt++;
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_req(input logic [W-1:0] d);
        bus.tx_data = d;
        bus.tx_req  = 1'b1;
        @(negedge clk);
        bus.tx_req  = 1'b0;
        bus.tx_data = W'($urandom);
    endtask

    // Selects the slave, gives the last dummy-phase rising edge, issues tx_req
    // and queues the bits the master will sample.
    task automatic start_frame(input logic [W-1:0] data, input int n_bits);
        bus.ssn = 1'b0;
        wait_neg(4);
        bus.sclk = 1'b1;
        wait_neg(3);
        pulse_req(data);
        check("oe_at_load", 32'(bus.miso_oe), 32'd1);
        check("busy_at_load", 32'(bus.tx_busy), 32'd1);
        for (int i = 0; i < n_bits; i++) exp_q.push_back(data[W-1-i]);
        wait_neg(1);
        bus.sclk = 1'b0;
    endtask

    // Runs n data-phase sclk cycles, sampling miso just before each rise
    task automatic clock_bits(input int n, input bit extra_req);
        logic e;
        for (int i = 0; i < n; i++) begin
            wait_neg(5);
            e = exp_q.pop_front();
            check($sformatf("bit%0d", i), 32'(bus.miso), 32'(e));
            bus.sclk = 1'b1;
            if (extra_req && i == 3) begin
                pulse_req(16'hDEAD);
                check("busy_on_extra_req", 32'(bus.tx_busy), 32'd1);
                wait_neg(4);
            end else if (i == W - 1) begin
                wait_neg(3);
                check("done_not_early", 32'(bus.tx_done), 32'd0);
                wait_neg(1);
                check("done_pulse", 32'(bus.tx_done), 32'd1);
                check("busy_during_done", 32'(bus.tx_busy), 32'd1);
                wait_neg(1);
                check("done_one_cycle", 32'(bus.tx_done), 32'd0);
                check("busy_after_done", 32'(bus.tx_busy), 32'd0);
                check("oe_after_done", 32'(bus.miso_oe), 32'd0);
            end else begin
                wait_neg(5);
            end
            bus.sclk = 1'b0;
        end
    endtask

    task automatic sclk_idle(input int n);
        for (int i = 0; i < n; i++) begin
            wait_neg(5);
            bus.sclk = 1'b1;
            wait_neg(5);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [W-1:0] data, input int n_bits, input bit extra_req);
        int d0;
        int a0;
        d0 = done_cnt;
        a0 = abort_cnt;
        start_frame(data, n_bits);
        clock_bits(n_bits, extra_req);
        wait_neg(5);
        bus.ssn = 1'b1;
        wait_neg(5);
        if (n_bits == W) begin
            check("done_count", 32'(done_cnt - d0), 32'd1);
            check("no_abort", 32'(abort_cnt - a0), 32'd0);
        end else begin
            check("abort_count", 32'(abort_cnt - a0), 32'd1);
            check("no_done", 32'(done_cnt - d0), 32'd0);
            check("oe_after_abort", 32'(bus.miso_oe), 32'd0);
            check("busy_after_abort", 32'(bus.tx_busy), 32'd0);
        end
        wait_neg(4);
    endtask

    initial begin
        int b0;
        int o0;
        reset       = 1'b0;
        bus.sclk    = 1'b0;
        bus.ssn     = 1'b1;
        bus.tx_req  = 1'b0;
        bus.tx_data = '0;
        wait_neg(3);
        check("reset_outputs", 32'({bus.miso, bus.miso_oe, bus.tx_busy, bus.tx_done, bus.tx_abort}), 32'd0);
        reset = 1'b1;
        wait_neg(3);
        check("idle_outputs", 32'({bus.miso, bus.miso_oe, bus.tx_busy, bus.tx_done, bus.tx_abort}), 32'd0);

        // Full read, then back-to-back all-ones / all-zeros frames
        run_frame(16'hA5C3, W, 1'b0);
        run_frame(16'hFFFF, W, 1'b0);
        run_frame(16'h0000, W, 1'b0);

        // Request while deselected is dropped
        bus.ssn = 1'b1;
        wait_neg(4);
        b0 = busy_cnt;
        o0 = oe_cnt;
        pulse_req(16'h1234);
        wait_neg(6);
        check("deselected_req_busy", 32'(busy_cnt - b0), 32'd0);
        check("deselected_req_oe", 32'(oe_cnt - o0), 32'd0);

        // Second request mid-frame does not disturb the word
        run_frame(16'h00FF, W, 1'b1);

        // Abort after five rising edges
        run_frame(16'h8001, 5, 1'b0);

        // Asynchronous reset after eight bits
        start_frame(16'hC3C3, 8);
        clock_bits(8, 1'b0);
        wait_neg(2);
        #2;
        reset = 1'b0;
        #1;
        check("reset_mid_frame", 32'({bus.miso, bus.miso_oe, bus.tx_busy, bus.tx_done, bus.tx_abort}), 32'd0);
        wait_neg(2);
        reset = 1'b1;
        b0 = busy_cnt;
        o0 = oe_cnt;
        sclk_idle(8);
        bus.ssn = 1'b1;
        wait_neg(6);
        bus.ssn = 1'b0;
        wait_neg(6);
        sclk_idle(4);
        bus.ssn = 1'b1;
        wait_neg(6);
        check("no_tx_after_reset_busy", 32'(busy_cnt - b0), 32'd0);
        check("no_tx_after_reset_oe", 32'(oe_cnt - o0), 32'd0);

        // Fresh request after reset transmits normally
        run_frame(16'h3C5A, W, 1'b0);

        check("miso_never_x", 32'(x_cnt), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
